dma_priority_arbiter: RTL and testbench
=======================================

# dma_priority_arbiter

Parametrised request/priority arbiter for the DMA controller: the successor to the fixed 4-channel priority logic. It synchronises N asynchronous DREQ lines and applies per-channel masking, programmable DREQ/DACK polarity and fixed or rotating priority. It runs the HRQ/HLDA bus-hold handshake with the CPU and drives one-hot DACK. It sits between the peripheral request pins and the timing-control block, which performs the transfers and reports their completion.

## Interface
- NCH, 4, number of DMA channels (2..8)
- SYNC_STAGES, 2, DREQ synchroniser depth (>=2)
- CH_W, $clog2(NCH), channel index width (derived, do not override)

- CLK  input  1  controller clock
- RESET_N  input  1  asynchronous, active-low reset
- DREQ  input  NCH  asynchronous channel requests, polarity per DREQ_SENSE_LOW
- HLDA  input  1  hold acknowledge from CPU, synchronous to CLK
- MASK  input  NCH  1 = channel masked
- DISABLE  input  1  controller disable: no new requests accepted
- ROTATE  input  1  0 = fixed priority (ch0 highest), 1 = rotating
- DEMAND  input  NCH  per channel: 1 = demand mode, 0 = single mode
- DREQ_SENSE_LOW  input  1  1 = DREQ active low
- DACK_SENSE_HIGH  input  1  1 = DACK active high
- XFER_DONE  input  1  one-cycle pulse from timing control: one transfer finished
- EOP  input  1  valid with XFER_DONE: terminal count or external EOP
- HRQ  output  1  hold request to CPU
- DACK  output  NCH  acknowledge, one-hot when active, polarity per DACK_SENSE_HIGH
- ACTIVE_CH  output  CH_W  index of the channel being serviced
- SVC_VALID  output  1  1 = bus held and channel granted; timing control may run cycles

## Operation
- pend[i] = synced DREQ[i] ^ DREQ_SENSE_LOW, & ~MASK[i], & ~DISABLE.
- Priority: fixed means ch0 highest. Rotating means the search starts at ptr, and ptr <= serviced+1 (mod NCH) on every exit from SERVICE.
- States are IDLE, HOLD_REQ, SERVICE and RELEASE:
  - IDLE: HRQ=0. If |pend, go to HOLD_REQ.
  - HOLD_REQ: HRQ=1. When HLDA=1:
    - resolve the winner from pend in that cycle, latch it into ACTIVE_CH and go to SERVICE;
    - if pend==0, go to RELEASE.
    - The winner is not fixed at request time.
  - SERVICE: HRQ=1, SVC_VALID=1, DACK[ACTIVE_CH] active. On XFER_DONE:
    - EOP=1, single mode, or ~pend[ACTIVE_CH] → RELEASE;
    - otherwise (demand mode, still pending) stay in SERVICE.
    - HLDA=0 in any cycle → RELEASE immediately (abort).
  - RELEASE: HRQ=0, DACK inactive, SVC_VALID=0. Stay until HLDA=0, then go to IDLE.
- MASK or DISABLE asserted on the active channel during SERVICE does not cut the current transfer. It takes effect at the next XFER_DONE via pend.
- Requests from other channels during SERVICE never pre-empt. They are re-arbitrated only after passing back through IDLE.
- DACK = dack_oh ^ {NCH{~DACK_SENSE_HIGH}}, where dack_oh is registered. Polarity changes apply combinationally.

## Timing
- Reset values:
  - state = IDLE, HRQ = 0, dack_oh = 0 (DACK all inactive per sense), ACTIVE_CH = 0, SVC_VALID = 0;
  - ptr = 0, synchroniser flops = 0.
- Reset is asynchronous: asserting it mid-SERVICE drops HRQ and DACK at once.
- Latency:
  - DREQ edge → HRQ=1: SYNC_STAGES+1 cycles.
  - HLDA=1 → DACK/SVC_VALID: 1 cycle.
  - XFER_DONE with release → HRQ=0: 1 cycle.
  - HLDA=0 in SERVICE → DACK inactive: 1 cycle.
- At most one DACK is active at any time. HRQ never rises in the same cycle HLDA is still high from a previous hold.
- XFER_DONE outside SERVICE is ignored.

## Structure
- Package dma_pkg holds:
  - dma_arb_state_e (IDLE, HOLD_REQ, SERVICE, RELEASE);
  - the NCH_DEFAULT constant;
  - the function prio_pick(pend, ptr, rotate) returning {valid, index}.
- Sub-module dma_req_sync: a parametrised NCH x SYNC_STAGES synchroniser with async active-low reset.
- The arbiter FSM, rotation pointer and DACK register live in the top module.

## Test plan
- NCH=4, fixed: DREQ=0b1010 → HRQ after 3 cycles; HLDA=1 → DACK one-hot ch1 next cycle; XFER_DONE in single mode → HRQ=0; drop HLDA → IDLE, then ch3 served.
- Rotating: ch0 and ch2 held continuously in single mode → service order 0,2,0,2 and ptr advances correctly; NCH=8 repeat gives wrap 7→0.
- Demand mode, ch2: DREQ held over 5 XFER_DONE pulses → DACK[2] stays active. EOP=1 on the 3rd pulse → release after 3.
- Polarity: DREQ_SENSE_LOW=1, DACK_SENSE_HIGH=1, DREQ[1] driven low → DACK=0b0010 when granted, 0b0000 otherwise, including during reset.
- DREQ withdrawn while in HOLD_REQ → on HLDA go to RELEASE with no DACK. HLDA dropped mid-SERVICE → DACK inactive in 1 cycle, no XFER_DONE required.
- RESET_N pulsed mid-SERVICE → HRQ=0, DACK inactive and SVC_VALID=0 asynchronously. MASK of active ch in demand mode → release at next XFER_DONE.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types, constants and the priority search used by the DMA request arbiter.
package dma_pkg;

  localparam int NCH_DEFAULT = 4;
  // The priority search is written once at the largest supported channel count;
  // callers zero-extend their request vector and pointer to this width.
  localparam int NCH_MAX     = 8;
  localparam int IDX_MAX_W   = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_REQ = 2'd1,
    SERVICE  = 2'd2,
    RELEASE  = 2'd3
  } dma_arb_state_e;

  // Returns {valid, index}. The search starts at ch0 in fixed mode and at ptr in
  // rotating mode, wrapping modulo nch. Channels at or above nch are never chosen.
  function automatic logic [IDX_MAX_W:0] prio_pick(
    input logic [NCH_MAX-1:0]   pend,
    input logic [IDX_MAX_W-1:0] ptr,
    input logic                 rotate,
    input int                   nch
  );
    logic                 found;
    logic [IDX_MAX_W-1:0] idx;
    int                   base;
    int                   cand;
    found = 1'b0;
    idx   = '0;
    base  = rotate ? int'(ptr) : 0;
    for (int k = 0; k < NCH_MAX; k++) begin
      cand = (base + k) % nch;
      if ((k < nch) && !found && pend[cand]) begin
        found = 1'b1;
        idx   = IDX_MAX_W'(cand);
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/dma_req_sync.sv
// Multi-flop synchroniser for the asynchronous per-channel DREQ lines.
module dma_req_sync #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] async_in,
  output logic [NCH-1:0] sync_out
);

  // Stage k of the chain occupies bits [k*NCH +: NCH]; stage 0 samples the pins.
  logic [SYNC_STAGES*NCH-1:0] chain;

  // Shift every channel one stage further per clock; reset clears all stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[(SYNC_STAGES-1)*NCH-1:0], async_in};
    end
  end

  assign sync_out = chain[SYNC_STAGES*NCH-1 -: NCH];

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA request arbiter: synchronises DREQ, picks a channel by fixed or rotating
// priority, runs the HRQ/HLDA hold handshake and drives a one-hot DACK.
//
// Handshake: HRQ asks the CPU for the bus; the CPU answers with HLDA. A channel is
// granted only while HLDA is high, and SVC_VALID=1 marks the cycles in which the
// timing control may run transfers. XFER_DONE is a one-cycle pulse that counts
// only while SVC_VALID=1. HLDA falling during service aborts it at once.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NCH         = NCH_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int CH_W        = $clog2(NCH)
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [NCH-1:0]  DREQ,
  input  logic            HLDA,
  input  logic [NCH-1:0]  MASK,
  input  logic            DISABLE,
  input  logic            ROTATE,
  input  logic [NCH-1:0]  DEMAND,
  input  logic            DREQ_SENSE_LOW,
  input  logic            DACK_SENSE_HIGH,
  input  logic            XFER_DONE,
  input  logic            EOP,
  output logic            HRQ,
  output logic [NCH-1:0]  DACK,
  output logic [CH_W-1:0] ACTIVE_CH,
  output logic            SVC_VALID,
  output logic [1:0]      STATE
);

  dma_arb_state_e       state, state_next;
  logic [NCH-1:0]       dreq_sync;
  logic [NCH-1:0]       pend;
  logic [NCH-1:0]       dack_oh, dack_next;
  logic [CH_W-1:0]      active_ch, active_next;
  logic [CH_W-1:0]      ptr, ptr_next, ptr_inc;
  logic [IDX_MAX_W:0]   pick;
  logic                 pick_valid;
  logic [CH_W-1:0]      pick_idx;

  dma_req_sync #(
    .NCH         (NCH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .async_in (DREQ),
    .sync_out (dreq_sync)
  );

  assign pend       = (dreq_sync ^ {NCH{DREQ_SENSE_LOW}}) & ~MASK & {NCH{~DISABLE}};
  assign pick       = prio_pick(NCH_MAX'(pend), IDX_MAX_W'(ptr), ROTATE, NCH);
  assign pick_valid = pick[IDX_MAX_W];
  assign pick_idx   = CH_W'(pick[IDX_MAX_W-1:0]);
  // Rotation restarts just after the channel that was serviced, wrapping at NCH.
  assign ptr_inc    = (active_ch == CH_W'(NCH - 1)) ? '0 : active_ch + CH_W'(1);

  // Next-state logic: arbitration at HLDA time, service exit on done/abort.
  always_comb begin
    state_next  = state;
    dack_next   = dack_oh;
    active_next = active_ch;
    ptr_next    = ptr;
    case (state)
      IDLE: begin
        if (|pend) state_next = HOLD_REQ;
      end
      HOLD_REQ: begin
        // The winner is resolved from the requests present when the bus arrives.
        if (HLDA) begin
          if (pick_valid) begin
            state_next  = SERVICE;
            active_next = pick_idx;
            dack_next   = NCH'(1) << pick_idx;
          end else begin
            state_next  = RELEASE;
          end
        end
      end
      SERVICE: begin
        if (!HLDA || (XFER_DONE && (EOP || !DEMAND[active_ch] || !pend[active_ch]))) begin
          state_next = RELEASE;
          dack_next  = '0;
          ptr_next   = ptr_inc;
        end
      end
      RELEASE: begin
        // Wait for the CPU to take the bus back before a new hold can start.
        if (!HLDA) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        dack_next  = '0;
      end
    endcase
  end

  // State, grant and rotation pointer registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      dack_oh   <= '0;
      active_ch <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_next;
      dack_oh   <= dack_next;
      active_ch <= active_next;
      ptr       <= ptr_next;
    end
  end

  assign HRQ       = (state == HOLD_REQ) || (state == SERVICE);
  assign SVC_VALID = (state == SERVICE);
  assign DACK      = dack_oh ^ {NCH{~DACK_SENSE_HIGH}};
  assign ACTIVE_CH = active_ch;
  assign STATE     = state;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: a 4-channel and an 8-channel instance.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ, MASK, DEMAND;
  logic       HLDA, DISABLE, ROTATE, DREQ_SENSE_LOW, DACK_SENSE_HIGH, XFER_DONE, EOP;
  logic       HRQ, SVC_VALID;
  logic [3:0] DACK;
  logic [1:0] ACTIVE_CH, STATE;

  logic [7:0] DREQ8, MASK8, DEMAND8, DACK8;
  logic       HRQ8, SVC_VALID8;
  logic [2:0] ACTIVE_CH8;
  logic [1:0] STATE8;

  int n_checks = 0;
  int n_fail   = 0;

  dma_priority_arbiter #(.NCH(4), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .MASK(MASK),
    .DISABLE(DISABLE), .ROTATE(ROTATE), .DEMAND(DEMAND),
    .DREQ_SENSE_LOW(DREQ_SENSE_LOW), .DACK_SENSE_HIGH(DACK_SENSE_HIGH),
    .XFER_DONE(XFER_DONE), .EOP(EOP), .HRQ(HRQ), .DACK(DACK),
    .ACTIVE_CH(ACTIVE_CH), .SVC_VALID(SVC_VALID), .STATE(STATE)
  );

  dma_priority_arbiter #(.NCH(8), .SYNC_STAGES(2)) dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ8), .HLDA(HLDA), .MASK(MASK8),
    .DISABLE(DISABLE), .ROTATE(ROTATE), .DEMAND(DEMAND8),
    .DREQ_SENSE_LOW(DREQ_SENSE_LOW), .DACK_SENSE_HIGH(DACK_SENSE_HIGH),
    .XFER_DONE(XFER_DONE), .EOP(EOP), .HRQ(HRQ8), .DACK(DACK8),
    .ACTIVE_CH(ACTIVE_CH8), .SVC_VALID(SVC_VALID8), .STATE(STATE8)
  );

  // Clock and global watchdog
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic reset_dut();
    DREQ = '0; MASK = '0; DEMAND = '0; HLDA = 0; DISABLE = 0; ROTATE = 0;
    DREQ_SENSE_LOW = 0; DACK_SENSE_HIGH = 1; XFER_DONE = 0; EOP = 0;
    DREQ8 = '0; MASK8 = '0; DEMAND8 = '0;
    RESET_N = 0;
    tick(2);
    RESET_N = 1;
    tick(1);
  endtask

  task automatic pulse_done(input logic eop);
    XFER_DONE = 1; EOP = eop;
    tick(1);
    XFER_DONE = 0; EOP = 0;
  endtask

  task automatic wait_hrq(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (HRQ === 1'b1) begin ok = 1; break; end
      tick(1);
    end
  endtask

  // One full single-mode service on either instance; reports the granted channel.
  task automatic serve(input bit use8, output int ch, output logic [7:0] dack, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if ((use8 ? HRQ8 : HRQ) === 1'b1) begin ok = 1; break; end
      tick(1);
    end
    HLDA = 1;
    tick(1);
    ch   = use8 ? int'(ACTIVE_CH8) : int'(ACTIVE_CH);
    dack = use8 ? DACK8 : {4'b0000, DACK};
    pulse_done(1'b0);
    HLDA = 0;
    tick(1);
  endtask

  // Scenarios
  task automatic test_reset();
    DACK_SENSE_HIGH = 1;
    RESET_N = 0;
    #1;
    n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL reset_hrq got=%b exp=0", HRQ); end
    n_checks++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL reset_dack got=%b exp=0000", DACK); end
    n_checks++; if (SVC_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_svc got=%b exp=0", SVC_VALID); end
    n_checks++; if (ACTIVE_CH !== 2'd0) begin n_fail++; $display("FAIL reset_active got=%0d exp=0", ACTIVE_CH); end
    n_checks++; if (STATE !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", STATE); end
    n_checks++; if (DACK8 !== 8'h00) begin n_fail++; $display("FAIL reset_dack8 got=%b exp=00000000", DACK8); end
    DACK_SENSE_HIGH = 0;
    #1;
    n_checks++; if (DACK !== 4'b1111) begin n_fail++; $display("FAIL reset_dack_low got=%b exp=1111", DACK); end
    DACK_SENSE_HIGH = 1;
    #1;
  endtask

  task automatic test_fixed();
    bit ok;
    reset_dut();
    DREQ = 4'b1010;
    tick(2);
    n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL fixed_hrq_early got=%b exp=0", HRQ); end
    tick(1);
    n_checks++; if (HRQ !== 1'b1) begin n_fail++; $display("FAIL fixed_hrq_lat got=%b exp=1", HRQ); end
    pulse_done(1'b0);
    n_checks++; if (SVC_VALID !== 1'b0 || HRQ !== 1'b1) begin n_fail++; $display("FAIL fixed_done_ignored got=svc%b/hrq%b exp=svc0/hrq1", SVC_VALID, HRQ); end
    HLDA = 1;
    tick(1);
    n_checks++; if (DACK !== 4'b0010) begin n_fail++; $display("FAIL fixed_dack_ch1 got=%b exp=0010", DACK); end
    n_checks++; if (ACTIVE_CH !== 2'd1) begin n_fail++; $display("FAIL fixed_active_ch1 got=%0d exp=1", ACTIVE_CH); end
    n_checks++; if (SVC_VALID !== 1'b1) begin n_fail++; $display("FAIL fixed_svc got=%b exp=1", SVC_VALID); end
    DREQ = 4'b1000;
    pulse_done(1'b0);
    n_checks++; if (HRQ !== 1'b0 || DACK !== 4'b0000) begin n_fail++; $display("FAIL fixed_release got=hrq%b/dack%b exp=hrq0/dack0000", HRQ, DACK); end
    tick(2);
    n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL fixed_hrq_while_hlda got=%b exp=0", HRQ); end
    HLDA = 0;
    tick(1);
    wait_hrq(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL fixed_ch3_hrq got=timeout exp=hrq1"); end
    HLDA = 1;
    tick(1);
    n_checks++; if (ACTIVE_CH !== 2'd3 || DACK !== 4'b1000) begin n_fail++; $display("FAIL fixed_ch3 got=ch%0d/dack%b exp=ch3/dack1000", ACTIVE_CH, DACK); end
    DREQ = 4'b0000;
    pulse_done(1'b0);
    HLDA = 0;
    tick(3);
  endtask

  task automatic test_rotate();
    int         ch;
    logic [7:0] dk;
    bit         ok;
    int         exp_rot[4] = '{0, 2, 0, 2};
    int         exp_w8[4]  = '{0, 7, 0, 7};
    reset_dut();
    ROTATE = 1;
    DREQ = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, ch, dk, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rot_hrq[%0d] got=timeout exp=hrq1", i); end
      n_checks++; if (ch != exp_rot[i] || dk !== (8'd1 << exp_rot[i])) begin n_fail++; $display("FAIL rot_order[%0d] got=ch%0d/dack%b exp=ch%0d", i, ch, dk, exp_rot[i]); end
    end
    ROTATE = 0;
    for (int i = 0; i < 2; i++) begin
      serve(1'b0, ch, dk, ok);
      n_checks++; if (ch != 0 || dk !== 8'h01) begin n_fail++; $display("FAIL fixed_order[%0d] got=ch%0d/dack%b exp=ch0", i, ch, dk); end
    end
    DREQ = 4'b0000;
    tick(3);
    reset_dut();
    ROTATE = 1;
    DREQ8 = 8'h81;
    for (int i = 0; i < 4; i++) begin
      serve(1'b1, ch, dk, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rot8_hrq[%0d] got=timeout exp=hrq1", i); end
      n_checks++; if (ch != exp_w8[i] || dk !== (8'd1 << exp_w8[i])) begin n_fail++; $display("FAIL rot8_order[%0d] got=ch%0d/dack%b exp=ch%0d", i, ch, dk, exp_w8[i]); end
    end
    DREQ8 = 8'h00;
    tick(3);
  endtask

  task automatic test_demand();
    bit ok;
    reset_dut();
    DEMAND = 4'b0100;
    DREQ = 4'b0100;
    wait_hrq(ok);
    HLDA = 1;
    tick(1);
    for (int p = 0; p < 5; p++) begin
      pulse_done(1'b0);
      n_checks++; if (DACK !== 4'b0100 || SVC_VALID !== 1'b1) begin n_fail++; $display("FAIL demand_hold[%0d] got=dack%b/svc%b exp=dack0100/svc1", p, DACK, SVC_VALID); end
    end
    pulse_done(1'b1);
    HLDA = 0;
    tick(1);
    wait_hrq(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL demand_rehrq got=timeout exp=hrq1"); end
    HLDA = 1;
    tick(1);
    for (int p = 1; p <= 3; p++) begin
      pulse_done(p == 3);
      if (p < 3) begin
        n_checks++; if (SVC_VALID !== 1'b1) begin n_fail++; $display("FAIL demand_eop_pre[%0d] got=%b exp=1", p, SVC_VALID); end
      end else begin
        n_checks++; if (SVC_VALID !== 1'b0 || HRQ !== 1'b0 || DACK !== 4'b0000) begin n_fail++; $display("FAIL demand_eop_rel got=svc%b/hrq%b/dack%b exp=0/0/0000", SVC_VALID, HRQ, DACK); end
      end
    end
    DREQ = 4'b0000;
    HLDA = 0;
    tick(3);
  endtask

  task automatic test_polarity();
    bit ok;
    reset_dut();
    MASK = 4'b1111;
    DREQ = 4'b1111;
    tick(3);
    DREQ_SENSE_LOW = 1;
    tick(1);
    MASK = 4'b0000;
    DREQ = 4'b1101;
    wait_hrq(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL pol_hrq got=timeout exp=hrq1"); end
    n_checks++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL pol_dack_idle got=%b exp=0000", DACK); end
    HLDA = 1;
    tick(1);
    n_checks++; if (DACK !== 4'b0010) begin n_fail++; $display("FAIL pol_dack_grant got=%b exp=0010", DACK); end
    DACK_SENSE_HIGH = 0;
    #1;
    n_checks++; if (DACK !== 4'b1101) begin n_fail++; $display("FAIL pol_dack_low got=%b exp=1101", DACK); end
    DACK_SENSE_HIGH = 1;
    DREQ = 4'b1111;
    pulse_done(1'b0);
    n_checks++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL pol_dack_rel got=%b exp=0000", DACK); end
    HLDA = 0;
    tick(3);
    MASK = 4'b1111;
    DREQ_SENSE_LOW = 0;
    DREQ = 4'b0000;
    tick(3);
  endtask

  task automatic test_withdraw_abort();
    bit ok;
    reset_dut();
    DREQ = 4'b0001;
    wait_hrq(ok);
    DREQ = 4'b0000;
    tick(3);
    HLDA = 1;
    tick(1);
    n_checks++; if (DACK !== 4'b0000 || SVC_VALID !== 1'b0 || HRQ !== 1'b0) begin n_fail++; $display("FAIL withdraw got=dack%b/svc%b/hrq%b exp=0000/0/0", DACK, SVC_VALID, HRQ); end
    HLDA = 0;
    tick(3);
    n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL withdraw_idle got=%b exp=0", HRQ); end
    DREQ = 4'b0010;
    wait_hrq(ok);
    HLDA = 1;
    tick(1);
    n_checks++; if (DACK !== 4'b0010) begin n_fail++; $display("FAIL abort_pre got=%b exp=0010", DACK); end
    HLDA = 0;
    tick(1);
    n_checks++; if (DACK !== 4'b0000 || SVC_VALID !== 1'b0 || HRQ !== 1'b0) begin n_fail++; $display("FAIL abort got=dack%b/svc%b/hrq%b exp=0000/0/0", DACK, SVC_VALID, HRQ); end
    DREQ = 4'b0000;
    tick(3);
  endtask

  task automatic test_reset_mid_and_mask();
    bit ok;
    reset_dut();
    DREQ = 4'b0100;
    wait_hrq(ok);
    HLDA = 1;
    tick(1);
    n_checks++; if (SVC_VALID !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got=%b exp=1", SVC_VALID); end
    #2;
    RESET_N = 0;
    #1;
    n_checks++; if (HRQ !== 1'b0 || DACK !== 4'b0000 || SVC_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid got=hrq%b/dack%b/svc%b exp=0/0000/0", HRQ, DACK, SVC_VALID); end
    reset_dut();
    DEMAND = 4'b0001;
    DREQ = 4'b0001;
    wait_hrq(ok);
    HLDA = 1;
    tick(1);
    pulse_done(1'b0);
    n_checks++; if (SVC_VALID !== 1'b1) begin n_fail++; $display("FAIL mask_demand_cont got=%b exp=1", SVC_VALID); end
    MASK = 4'b0001;
    tick(2);
    n_checks++; if (SVC_VALID !== 1'b1 || DACK !== 4'b0001) begin n_fail++; $display("FAIL mask_no_cut got=svc%b/dack%b exp=1/0001", SVC_VALID, DACK); end
    pulse_done(1'b0);
    n_checks++; if (SVC_VALID !== 1'b0 || HRQ !== 1'b0) begin n_fail++; $display("FAIL mask_release got=svc%b/hrq%b exp=0/0", SVC_VALID, HRQ); end
    HLDA = 0;
    DREQ = 4'b0000;
    tick(3);
  endtask

  // Sequence and report
  initial begin
    reset_dut();
    test_reset();
    test_fixed();
    test_rotate();
    test_demand();
    test_polarity();
    test_withdraw_abort();
    test_reset_mid_and_mask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
